// File: rtl/chord_voice_bank.sv
// Multi-voice note bank: per-voice note/duration/elapsed/history slots with explicit or
// lowest-finished-voice load targeting. Auto allocation is built only under CHORD_VOICE_BANK_AUTO_ALLOC_EN.
module chord_voice #(
    parameter int   NOTE_W     = 6,
    parameter int   DUR_W      = 6,
    parameter int   HIST_DEPTH = 2,
    parameter logic WAITER     = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         tick,
    input  logic                         done_waiting,
    input  logic [NOTE_W-1:0]            load_note,
    input  logic [DUR_W-1:0]             load_duration,
    output logic [NOTE_W-1:0]            note,
    output logic [DUR_W-1:0]             duration,
    output logic [DUR_W-1:0]             elapsed,
    output logic [HIST_DEPTH*NOTE_W-1:0] hist,
    output logic                         done
);
    logic [HIST_DEPTH-1:0][NOTE_W-1:0] hist_q;
    logic                              count;

    assign done  = (elapsed == duration);
    // Counting stops at done, so elapsed saturates at duration instead of wrapping.
    assign count = tick & (WAITER | ~done_waiting) & ~done;
    assign hist  = hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            note     <= '0;
            duration <= '0;
            elapsed  <= '0;
            hist_q   <= '0;
        end else if (load) begin
            note      <= load_note;
            duration  <= load_duration;
            elapsed   <= '0;
            hist_q[0] <= note;
            for (int k = 1; k < HIST_DEPTH; k++) hist_q[k] <= hist_q[k-1];
        end else if (count) begin
            elapsed <= elapsed + 1'b1;
        end
    end
endmodule

module chord_voice_bank #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int HIST_DEPTH = 2,
    localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    parameter logic [NUM_VOICES-1:0] WAITER_MASK = NUM_VOICES'(1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   play_enable,
    input  logic                                   beat,
    input  logic                                   done_waiting,
    input  logic                                   load_valid,
    input  logic                                   load_auto,
    input  logic [VW-1:0]                          load_voice,
    input  logic [NOTE_W-1:0]                      load_note,
    input  logic [DUR_W-1:0]                       load_duration,
    output logic                                   load_ready,
    output logic                                   load_accepted,
    output logic [VW-1:0]                          load_granted_voice,
    output logic [NUM_VOICES*NOTE_W-1:0]           curr_note,
    output logic [NUM_VOICES*DUR_W-1:0]            curr_duration,
    output logic [NUM_VOICES*DUR_W-1:0]            curr_elapsed,
    output logic [NUM_VOICES*HIST_DEPTH*NOTE_W-1:0] hist_note,
    output logic [NUM_VOICES-1:0]                  done,
    output logic                                   all_done
);
    logic          explicit_ok;
    logic          take;
    logic [VW-1:0] target;

    assign explicit_ok = ({1'b0, load_voice} < (VW+1)'(NUM_VOICES));

`ifdef CHORD_VOICE_BANK_AUTO_ALLOC_EN
    logic          auto_hit;
    logic [VW-1:0] auto_idx;

    // Descending scan leaves the lowest-index finished voice as the winner.
    always_comb begin
        auto_hit = 1'b0;
        auto_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (done[v]) begin
                auto_hit = 1'b1;
                auto_idx = VW'(v);
            end
        end
    end

    assign load_ready = load_auto ? auto_hit : explicit_ok;
    assign target     = load_auto ? auto_idx : load_voice;
`else
    logic unused_auto;
    assign unused_auto = load_auto;
    assign load_ready  = explicit_ok;
    assign target      = load_voice;
`endif

    assign take     = load_valid & load_ready;
    assign all_done = &done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_accepted      <= 1'b0;
            load_granted_voice <= '0;
        end else begin
            load_accepted <= take;
            if (take) load_granted_voice <= target;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        chord_voice #(
            .NOTE_W     (NOTE_W),
            .DUR_W      (DUR_W),
            .HIST_DEPTH (HIST_DEPTH),
            .WAITER     (WAITER_MASK[v])
        ) u_voice (
            .clk           (clk),
            .reset         (reset),
            .load          (take && (target == VW'(v))),
            .tick          (beat & play_enable),
            .done_waiting  (done_waiting),
            .load_note     (load_note),
            .load_duration (load_duration),
            .note          (curr_note[v*NOTE_W +: NOTE_W]),
            .duration      (curr_duration[v*DUR_W +: DUR_W]),
            .elapsed       (curr_elapsed[v*DUR_W +: DUR_W]),
            .hist          (hist_note[v*HIST_DEPTH*NOTE_W +: HIST_DEPTH*NOTE_W]),
            .done          (done[v])
        );
    end
endmodule
